// File: rtl/mem_level.sv
`default_nettype none
`ifndef WIDTH_INSTR
`define WIDTH_INSTR 31:0
`endif
`ifndef WIDTH_T
`define WIDTH_T 2:0
`endif
// ============================================================================
// Module      : mem_level
// Description : MEM pipeline stage - data memory with byte/half/word stores,
//               extending loads, store-data forwarding and the WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_level #(
    parameter int DM_WORDS = 4096,
    parameter int DM_AW    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                clr,
    input  logic [`WIDTH_INSTR] instr_MEM,
    input  logic [31:0]         PC_MEM,
    input  logic [31:0]         aluOut_MEM,
    input  logic [31:0]         memWriteData_MEM,
    input  logic [4:0]          addrRt_MEM,
    input  logic [4:0]          regWriteAddr_MEM,
    input  logic [31:0]         regWriteData_MEM,
    input  logic [`WIDTH_T]     Tnew_MEM,
    input  logic [4:0]          regaddr_WB,
    input  logic [31:0]         regdata_WB,
    output logic [`WIDTH_INSTR] instr_WB,
    output logic [31:0]         PC_WB,
    output logic [4:0]          regWriteAddr_WB,
    output logic [31:0]         regWriteData_WB,
    output logic [`WIDTH_T]     Tnew_WB,
    output logic                dmWE,
    output logic [31:0]         dmAddr,
    output logic [31:0]         dmWData
);

    localparam logic [5:0] c_op_lb  = 6'h20;
    localparam logic [5:0] c_op_lh  = 6'h21;
    localparam logic [5:0] c_op_lw  = 6'h23;
    localparam logic [5:0] c_op_lbu = 6'h24;
    localparam logic [5:0] c_op_lhu = 6'h25;
    localparam logic [5:0] c_op_sb  = 6'h28;
    localparam logic [5:0] c_op_sh  = 6'h29;
    localparam logic [5:0] c_op_sw  = 6'h2b;
    localparam logic [`WIDTH_T] c_t_one  = 1;
    localparam logic [`WIDTH_T] c_t_zero = '0;

    logic [31:0]      r_mem [DM_WORDS];
    logic [5:0]       w_op;
    logic [DM_AW-1:0] w_idx;
    logic [31:0]      w_word;
    logic [31:0]      w_st_data;
    logic             w_is_store;
    logic             w_we;
    logic [31:0]      w_merged;
    logic [15:0]      w_half;
    logic [7:0]       w_byte;
    logic             w_is_load;
    logic [31:0]      w_load;
    logic [31:0]      w_wb_data;

    assign w_op   = instr_MEM[31:26];
    assign w_idx  = aluOut_MEM[DM_AW+1:2];
    assign w_word = r_mem[w_idx];

    // A store whose source register is being written back this cycle takes the fresh value.
    assign w_st_data  = (regaddr_WB == addrRt_MEM && regaddr_WB != 5'd0) ? regdata_WB
                                                                         : memWriteData_MEM;
    assign w_is_store = (w_op == c_op_sw) || (w_op == c_op_sh) || (w_op == c_op_sb);
    assign w_we       = w_is_store && !stall && !reset;

    always_comb begin
        w_merged = w_word;
        if (w_op == c_op_sw) begin
            w_merged = w_st_data;
        end else if (w_op == c_op_sh) begin
            if (aluOut_MEM[1]) w_merged[31:16] = w_st_data[15:0];
            else               w_merged[15:0]  = w_st_data[15:0];
        end else if (w_op == c_op_sb) begin
            case (aluOut_MEM[1:0])
                2'd0:    w_merged[7:0]   = w_st_data[7:0];
                2'd1:    w_merged[15:8]  = w_st_data[7:0];
                2'd2:    w_merged[23:16] = w_st_data[7:0];
                default: w_merged[31:24] = w_st_data[7:0];
            endcase
        end
    end

    assign w_half = aluOut_MEM[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (aluOut_MEM[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_is_load = 1'b1;
        w_load    = w_word;
        case (w_op)
            c_op_lw:  w_load = w_word;
            c_op_lh:  w_load = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_load = {16'h0000, w_half};
            c_op_lb:  w_load = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_load = {24'h000000, w_byte};
            default:  w_is_load = 1'b0;
        endcase
    end

    assign w_wb_data = w_is_load ? w_load : regWriteData_MEM;

    assign dmWE    = w_we;
    assign dmAddr  = {aluOut_MEM[31:2], 2'b00};
    assign dmWData = w_merged;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            instr_WB        <= '0;
            PC_WB           <= '0;
            regWriteAddr_WB <= '0;
            regWriteData_WB <= '0;
            Tnew_WB         <= '0;
        end else if (!stall) begin
            instr_WB        <= instr_MEM;
            PC_WB           <= PC_MEM;
            regWriteAddr_WB <= regWriteAddr_MEM;
            regWriteData_WB <= w_wb_data;
            Tnew_WB         <= (Tnew_MEM != c_t_zero) ? Tnew_MEM - c_t_one : c_t_zero;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_level.sv
`default_nettype none
`ifndef WIDTH_INSTR
`define WIDTH_INSTR 31:0
`endif
`ifndef WIDTH_T
`define WIDTH_T 2:0
`endif
// ============================================================================
// Module      : tb_mem_level
// Description : Self-checking bench for mem_level against a byte-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_level;
    localparam int DM_WORDS = 4096;
    localparam int DM_AW    = 12;
    localparam int NBYTES   = DM_WORDS * 4;
    localparam logic [5:0] OP_ALU = 6'h00, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                           OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29,
                           OP_SW = 6'h2b;

    logic clk = 1'b0;
    logic reset, stall, clr;
    logic [`WIDTH_INSTR] instr_MEM, instr_WB;
    logic [31:0] PC_MEM, aluOut_MEM, memWriteData_MEM, regWriteData_MEM, regdata_WB;
    logic [4:0]  addrRt_MEM, regWriteAddr_MEM, regaddr_WB, regWriteAddr_WB;
    logic [`WIDTH_T] Tnew_MEM, Tnew_WB;
    logic [31:0] PC_WB, regWriteData_WB, dmAddr, dmWData;
    logic        dmWE;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]          mbytes [NBYTES];
    logic [`WIDTH_INSTR] exp_instr;
    logic [31:0]         exp_pc, exp_rwd;
    logic [4:0]          exp_rwa;
    logic [`WIDTH_T]     exp_tnew;

    mem_level #(.DM_WORDS(DM_WORDS), .DM_AW(DM_AW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr),
        .instr_MEM(instr_MEM), .PC_MEM(PC_MEM), .aluOut_MEM(aluOut_MEM),
        .memWriteData_MEM(memWriteData_MEM), .addrRt_MEM(addrRt_MEM),
        .regWriteAddr_MEM(regWriteAddr_MEM), .regWriteData_MEM(regWriteData_MEM),
        .Tnew_MEM(Tnew_MEM), .regaddr_WB(regaddr_WB), .regdata_WB(regdata_WB),
        .instr_WB(instr_WB), .PC_WB(PC_WB), .regWriteAddr_WB(regWriteAddr_WB),
        .regWriteData_WB(regWriteData_WB), .Tnew_WB(Tnew_WB),
        .dmWE(dmWE), .dmAddr(dmAddr), .dmWData(dmWData)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_store(input logic [5:0] op);
        return op == OP_SW || op == OP_SH || op == OP_SB;
    endfunction

    function automatic bit is_load(input logic [5:0] op);
        return op == OP_LW || op == OP_LH || op == OP_LHU || op == OP_LB || op == OP_LBU;
    endfunction

    function automatic int bidx(input logic [31:0] a);
        return int'(a % NBYTES);
    endfunction

    function automatic logic [31:0] fwd_data();
        return (regaddr_WB == addrRt_MEM && regaddr_WB != 5'd0) ? regdata_WB : memWriteData_MEM;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
        int b = bidx(a);
        int w = b - (b % 4);
        int h = b - (b % 2);
        logic [31:0] word = {mbytes[w+3], mbytes[w+2], mbytes[w+1], mbytes[w]};
        logic [15:0] half = {mbytes[h+1], mbytes[h]};
        logic [7:0]  by   = mbytes[b];
        case (op)
            OP_LW:   return word;
            OP_LH:   return {{16{half[15]}}, half};
            OP_LHU:  return {16'h0, half};
            OP_LB:   return {{24{by[7]}}, by};
            OP_LBU:  return {24'h0, by};
            default: return 32'h0;
        endcase
    endfunction

    // The word the memory would hold after this op's store (unchanged for non-stores).
    function automatic logic [31:0] model_merged(input logic [5:0] op, input logic [31:0] a,
                                                 input logic [31:0] d);
        logic [7:0] t [4];
        int b = bidx(a);
        int w = b - (b % 4);
        for (int k = 0; k < 4; k++) t[k] = mbytes[w+k];
        case (op)
            OP_SW: for (int k = 0; k < 4; k++) t[k] = d[8*k +: 8];
            OP_SH: begin t[b % 4 - b % 2] = d[7:0]; t[b % 4 - b % 2 + 1] = d[15:8]; end
            OP_SB: t[b % 4] = d[7:0];
            default: ;
        endcase
        return {t[3], t[2], t[1], t[0]};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rt, input logic [4:0] wba, input logic [31:0] wbd);
        instr_MEM        = {op, 26'($urandom)};
        PC_MEM           = $urandom;
        aluOut_MEM       = addr;
        memWriteData_MEM = wdata;
        addrRt_MEM       = rt;
        regWriteAddr_MEM = 5'($urandom);
        regWriteData_MEM = $urandom;
        Tnew_MEM         = 3'($urandom_range(0, 7));
        regaddr_WB       = wba;
        regdata_WB       = wbd;
    endtask

    // Advance the model by one edge from the current inputs, then clock the DUT.
    task automatic step();
        logic [5:0]  op = instr_MEM[31:26];
        logic [31:0] ld = model_load(op, aluOut_MEM);
        logic [31:0] mw = model_merged(op, aluOut_MEM, fwd_data());
        int          w  = bidx(aluOut_MEM) - (bidx(aluOut_MEM) % 4);
        if (reset) begin
            foreach (mbytes[i]) mbytes[i] = 8'h00;
            exp_instr = '0; exp_pc = '0; exp_rwa = '0; exp_rwd = '0; exp_tnew = '0;
        end else begin
            if (is_store(op) && !stall)
                for (int k = 0; k < 4; k++) mbytes[w+k] = mw[8*k +: 8];
            if (clr) begin
                exp_instr = '0; exp_pc = '0; exp_rwa = '0; exp_rwd = '0; exp_tnew = '0;
            end else if (!stall) begin
                exp_instr = instr_MEM;
                exp_pc    = PC_MEM;
                exp_rwa   = regWriteAddr_MEM;
                exp_rwd   = is_load(op) ? ld : regWriteData_MEM;
                exp_tnew  = (Tnew_MEM >= 1) ? Tnew_MEM - 3'd1 : 3'd0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; clr = 1'b0;
        drive(OP_SW, 32'h0000_1237, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (dmWE !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %0b want 0", dmWE); end
        n_cmp++; if (dmAddr !== 32'h0000_1234) begin n_bad++; $display("FAIL reset_addr: got %h want 00001234", dmAddr); end
        step(); step();
        n_cmp++; if (instr_WB !== '0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr_WB); end
        n_cmp++; if (PC_WB !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", PC_WB); end
        n_cmp++; if (regWriteAddr_WB !== 5'h0) begin n_bad++; $display("FAIL reset_rwa: got %h want 0", regWriteAddr_WB); end
        n_cmp++; if (regWriteData_WB !== 32'h0) begin n_bad++; $display("FAIL reset_rwd: got %h want 0", regWriteData_WB); end
        n_cmp++; if (Tnew_WB !== '0) begin n_bad++; $display("FAIL reset_tnew: got %h want 0", Tnew_WB); end
        reset = 1'b0;
    endtask

    task automatic test_word_byte();
        drive(OP_SW, 32'h10, 32'h1122_3344, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (dmWE !== 1'b1) begin n_bad++; $display("FAIL sw_we: got %0b want 1", dmWE); end
        n_cmp++; if (dmAddr !== 32'h10) begin n_bad++; $display("FAIL sw_addr: got %h want 00000010", dmAddr); end
        n_cmp++; if (dmWData !== 32'h1122_3344) begin n_bad++; $display("FAIL sw_data: got %h want 11223344", dmWData); end
        step();
        drive(OP_LW, 32'h10, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'h1122_3344) begin n_bad++; $display("FAIL lw_10: got %h want 11223344", regWriteData_WB); end
        drive(OP_SB, 32'h13, 32'h5555_55AB, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (dmWData !== 32'hAB22_3344) begin n_bad++; $display("FAIL sb_merge: got %h want ab223344", dmWData); end
        step();
        drive(OP_LB, 32'h13, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'hFFFF_FFAB) begin n_bad++; $display("FAIL lb_13: got %h want ffffffab", regWriteData_WB); end
        drive(OP_LBU, 32'h13, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'h0000_00AB) begin n_bad++; $display("FAIL lbu_13: got %h want 000000ab", regWriteData_WB); end
        drive(OP_LW, 32'h10, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'hAB22_3344) begin n_bad++; $display("FAIL lw_after_sb: got %h want ab223344", regWriteData_WB); end
    endtask

    task automatic test_halfword();
        drive(OP_SH, 32'h23, 32'h1234_8001, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (dmAddr !== 32'h20) begin n_bad++; $display("FAIL sh_addr: got %h want 00000020", dmAddr); end
        n_cmp++; if (dmWData !== 32'h8001_0000) begin n_bad++; $display("FAIL sh_merge: got %h want 80010000", dmWData); end
        step();
        drive(OP_LH, 32'h22, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_22: got %h want ffff8001", regWriteData_WB); end
        drive(OP_LHU, 32'h22, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_22: got %h want 00008001", regWriteData_WB); end
        drive(OP_LW, 32'h20, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'h8001_0000) begin n_bad++; $display("FAIL lw_20: got %h want 80010000", regWriteData_WB); end
    endtask

    task automatic test_forwarding();
        drive(OP_SW, 32'h30, 32'h1, 5'd5, 5'd5, 32'hDEAD_0000);
        #1;
        n_cmp++; if (dmWData !== 32'hDEAD_0000) begin n_bad++; $display("FAIL fwd_hit: got %h want dead0000", dmWData); end
        step();
        drive(OP_LW, 32'h30, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'hDEAD_0000) begin n_bad++; $display("FAIL fwd_stored: got %h want dead0000", regWriteData_WB); end
        drive(OP_SW, 32'h34, 32'h1, 5'd5, 5'd0, 32'hDEAD_0000);
        #1;
        n_cmp++; if (dmWData !== 32'h1) begin n_bad++; $display("FAIL fwd_wb0: got %h want 00000001", dmWData); end
        step();
        drive(OP_SW, 32'h38, 32'h1, 5'd0, 5'd0, 32'hDEAD_0000);
        #1;
        n_cmp++; if (dmWData !== 32'h1) begin n_bad++; $display("FAIL fwd_r0: got %h want 00000001", dmWData); end
        step();
    endtask

    task automatic test_stall_clr();
        logic [31:0] held, sw_rwd;
        drive(OP_ALU, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0);
        regWriteData_MEM = 32'hCAFE_0001;
        step();
        held = 32'hCAFE_0001;
        stall = 1'b1;
        drive(OP_SW, 32'h40, 32'h77, 5'd0, 5'd0, 32'h0);
        sw_rwd = regWriteData_MEM;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (dmWE !== 1'b0) begin n_bad++; $display("FAIL stall_we: got %0b want 0", dmWE); end
            step();
            n_cmp++; if (regWriteData_WB !== held) begin n_bad++; $display("FAIL stall_hold: got %h want %h", regWriteData_WB, held); end
        end
        stall = 1'b0;
        #1;
        n_cmp++; if (dmWE !== 1'b1) begin n_bad++; $display("FAIL unstall_we: got %0b want 1", dmWE); end
        step();
        n_cmp++; if (regWriteData_WB !== sw_rwd) begin n_bad++; $display("FAIL unstall_capture: got %h want %h", regWriteData_WB, sw_rwd); end
        clr = 1'b1;
        drive(OP_SW, 32'h44, 32'h99, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (dmWE !== 1'b1) begin n_bad++; $display("FAIL clr_we: got %0b want 1", dmWE); end
        step();
        n_cmp++; if (regWriteData_WB !== 32'h0 || PC_WB !== 32'h0 || instr_WB !== '0 || Tnew_WB !== '0 || regWriteAddr_WB !== 5'h0)
            begin n_bad++; $display("FAIL clr_bubble: got pc=%h rwd=%h want all zero", PC_WB, regWriteData_WB); end
        clr = 1'b0;
        drive(OP_LW, 32'h40, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'h77) begin n_bad++; $display("FAIL stall_store: got %h want 00000077", regWriteData_WB); end
        drive(OP_LW, 32'h44, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'h99) begin n_bad++; $display("FAIL clr_store: got %h want 00000099", regWriteData_WB); end
    endtask

    task automatic test_reset_mem();
        drive(OP_SW, 32'h4, 32'h5, 5'd0, 5'd0, 32'h0); step();
        reset = 1'b1;
        drive(OP_SW, 32'h8, 32'hF, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (dmWE !== 1'b0) begin n_bad++; $display("FAIL reset_midstore_we: got %0b want 0", dmWE); end
        step();
        reset = 1'b0;
        n_cmp++; if (regWriteData_WB !== 32'h0 || PC_WB !== 32'h0 || instr_WB !== '0)
            begin n_bad++; $display("FAIL reset_wb: got rwd=%h pc=%h want 0", regWriteData_WB, PC_WB); end
        drive(OP_LW, 32'h4, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'h0) begin n_bad++; $display("FAIL reset_mem_4: got %h want 0", regWriteData_WB); end
        drive(OP_LW, 32'h8, 32'h0, 5'd0, 5'd0, 32'h0); step();
        n_cmp++; if (regWriteData_WB !== 32'h0) begin n_bad++; $display("FAIL reset_mem_8: got %h want 0", regWriteData_WB); end
        drive(OP_ALU, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0); Tnew_MEM = 3'd2; step();
        n_cmp++; if (Tnew_WB !== 3'd1) begin n_bad++; $display("FAIL tnew_2: got %0d want 1", Tnew_WB); end
        drive(OP_ALU, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0); Tnew_MEM = 3'd0; step();
        n_cmp++; if (Tnew_WB !== 3'd0) begin n_bad++; $display("FAIL tnew_0: got %0d want 0", Tnew_WB); end
    endtask

    task automatic test_random();
        logic [5:0] ops [9] = '{OP_ALU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        for (int it = 0; it < 400; it++) begin
            logic [5:0]  op   = ops[$urandom_range(0, 8)];
            logic [31:0] addr = 32'($urandom_range(0, 127)) | (32'($urandom_range(0, 7)) << 14);
            logic [31:0] ewd;
            logic        ewe;
            stall = ($urandom_range(0, 5) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 59) == 0);
            drive(op, addr, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom);
            ewd = model_merged(op, addr, fwd_data());
            ewe = is_store(op) && !stall && !reset;
            #1;
            n_cmp++; if (dmWE !== ewe) begin n_bad++; $display("FAIL rnd_we it=%0d: got %0b want %0b", it, dmWE, ewe); end
            n_cmp++; if (dmAddr !== (addr & 32'hFFFF_FFFC)) begin n_bad++; $display("FAIL rnd_addr it=%0d: got %h want %h", it, dmAddr, addr & 32'hFFFF_FFFC); end
            n_cmp++; if (dmWData !== ewd) begin n_bad++; $display("FAIL rnd_wdata it=%0d: got %h want %h", it, dmWData, ewd); end
            step();
            n_cmp++; if (regWriteData_WB !== exp_rwd) begin n_bad++; $display("FAIL rnd_rwd it=%0d: got %h want %h", it, regWriteData_WB, exp_rwd); end
            n_cmp++; if (instr_WB !== exp_instr || PC_WB !== exp_pc || regWriteAddr_WB !== exp_rwa)
                begin n_bad++; $display("FAIL rnd_regs it=%0d: got pc=%h want %h", it, PC_WB, exp_pc); end
            n_cmp++; if (Tnew_WB !== exp_tnew) begin n_bad++; $display("FAIL rnd_tnew it=%0d: got %0d want %0d", it, Tnew_WB, exp_tnew); end
        end
        stall = 1'b0; clr = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; clr = 1'b0;
        foreach (mbytes[i]) mbytes[i] = 8'h00;
        drive(OP_ALU, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0);
        test_reset();
        test_word_byte();
        test_halfword();
        test_forwarding();
        test_stall_clr();
        test_reset_mem();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_level.md
MEM_LEVEL -- requirements
Module: MEM_LEVEL

Interface
REQ-001 SHALL have parameter DM_WORDS, default 4096: data memory depth in 32-bit words, a power of two.
REQ-002 SHALL have parameter DM_AW, default 12: word-index width, equal to log2(DM_WORDS).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port stall, input, 1 bit: holds the WB pipeline register and suppresses memory writes.
REQ-006 SHALL have port clr, input, 1 bit: loads a bubble (all zeros) into the WB pipeline register.
REQ-007 SHALL have ports instr_MEM [`WIDTH_INSTR], PC_MEM[32], aluOut_MEM[32], memWriteData_MEM[32], addrRt_MEM[5], regWriteAddr_MEM[5], regWriteData_MEM[32], Tnew_MEM [`WIDTH_T], all inputs: the EX-stage register contents.
REQ-008 SHALL have ports regaddr_WB[5] and regdata_WB[32], inputs: the register write-back being committed this cycle, used for forwarding.
REQ-009 SHALL have outputs instr_WB, PC_WB, regWriteAddr_WB, regWriteData_WB and Tnew_WB: registered, same widths as their _MEM counterparts.
REQ-010 SHALL have outputs dmWE[1], dmAddr[32] and dmWData[32]: combinational store trace giving the enable, the byte address and the merged word written.

Function
REQ-011 SHALL hold DM_WORDS x 32-bit words; word index = aluOut_MEM[DM_AW+1:2]; higher address bits are ignored, so addresses wrap modulo DM_WORDS*4.
REQ-012 Store data SHALL be forwarded: if regaddr_WB==addrRt_MEM and regaddr_WB!=0, use regdata_WB; otherwise use memWriteData_MEM.
REQ-013 SW SHALL write the full word; address bits [1:0] are ignored.
REQ-014 SH SHALL write data[15:0] into halfword aluOut_MEM[1]; bit 0 is ignored; the other half of the word is preserved.
REQ-015 SB SHALL write data[7:0] into byte aluOut_MEM[1:0]; the other bytes are preserved.
REQ-016 Byte lanes are little-endian: byte 0 = bits [7:0].
REQ-017 A memory write SHALL occur at the rising edge only when the instruction is a store, stall=0 and reset=0; clr does not block the write of the current store.
REQ-018 dmWE SHALL equal the write condition in REQ-017; dmAddr = {aluOut_MEM[31:2],2'b00}; dmWData = the post-merge word.
REQ-019 Memory read SHALL be combinational from the current array contents.
REQ-020 LW SHALL return the word; LH/LHU the halfword at aluOut_MEM[1]; LB/LBU the byte at aluOut_MEM[1:0]; LH/LB sign-extend, LHU/LBU zero-extend.
REQ-021 regWriteData for the next stage SHALL be the extended load result for loads and regWriteData_MEM for all other instructions.
REQ-022 Tnew SHALL decrement: Tnew_WB <= (Tnew_MEM>=1) ? Tnew_MEM-1 : 0.
REQ-023 WB register priority SHALL be: reset or clr -> all zero; else if !stall -> capture; else hold.
REQ-024 A store followed by a load to the same word in the next cycle SHALL read the newly written data (the write is done at the prior edge).
REQ-025 There is no read/write conflict within a cycle, because only one instruction occupies MEM.

Reset
REQ-026 On reset, every WB output SHALL be 0 and every memory word SHALL be 0; at time zero, all registers and memory SHALL be 0.
REQ-027 Reset asserted mid-store SHALL suppress that write.
REQ-028 Combinational outputs SHALL follow their inputs during reset, except dmWE, which SHALL be 0.

Verification
REQ-029 SW addr 0x10 data 0x11223344, then LW 0x10 -> regWriteData_WB=0x11223344 one cycle after the load enters; dmWE=1, dmAddr=0x10.
REQ-030 After REQ-029: SB 0x13 data 0xAB, then LB 0x13 -> 0xFFFFFFAB; LBU 0x13 -> 0x000000AB; LW 0x10 -> 0xAB223344.
REQ-031 SH 0x22 data 0x8001 into a zero word, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> 0x80010000.
REQ-032 SW with addrRt_MEM=5, regaddr_WB=5, regdata_WB=0xDEAD0000, memWriteData_MEM=0x1 -> stored 0xDEAD0000; same case with regaddr_WB=0 -> 0x1 stored.
REQ-033 Store with stall=1 for 2 cycles -> dmWE=0 and WB outputs held; stall released -> exactly one write; clr=1 -> WB outputs 0 next edge.
REQ-034 Write 0x5 to address 0x4; assert reset one cycle -> all WB outputs 0; LW 0x4 -> 0; Tnew_MEM=2 -> Tnew_WB=1; Tnew_MEM=0 -> Tnew_WB=0.
